// File: rtl/alu_seq.sv
// Sequential ALU/shifter: one-cycle ALU, iterative 1-bit-per-cycle shifter, held cf/zf flags.
// Optional ALU_OVF_EN adds a registered signed-overflow flag (vf).
//   state   | meaning
//   S_IDLE  | waiting for an operation, in_ready=1
//   S_SHIFT | shifting one bit per cycle, counter counts down to 1
//   S_DONE  | result valid, held until out_ready
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op_alu,
    input  logic [2:0]         op_shf,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     result,
    output logic               cf,
    output logic               zf,
    input  logic               cf_wr,
    input  logic               cf_wdata
`ifdef ALU_OVF_EN
    ,
    output logic               vf
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state;
    logic [2:0]         mode;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   xa, ya, alu_data, d;
    logic [WIDTH:0]     sum, shf_next;
    logic               cin, cf_eff, alu_carry, is_add, accept, drain, do_shift, c;
`ifdef ALU_OVF_EN
    logic               vf_pend, alu_vf;
`endif

    always_comb begin
        in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
        accept   = in_valid && in_ready;
        drain    = (state == S_DONE) && out_ready;
        // a direct write wins, else forward the carry that is draining this very cycle
        cf_eff   = cf_wr ? cf_wdata : ((accept && drain) ? result[WIDTH] : cf);
        do_shift = (op_shf != 3'b000) && (shamt != '0);

        xa = (op_alu[3:1] == 3'b110) ? ~x : x;
        ya = (op_alu[3:1] == 3'b010) ? ~y : y;
        if (op_alu[2:0] == 3'b100)
            cin = 1'b1;
        else if (op_alu == 4'b0101 || (op_alu[3] && op_alu[1:0] == 2'b01))
            cin = cf_eff;
        else
            cin = 1'b0;
        sum = {1'b0, xa} + {1'b0, ya} + {{WIDTH{1'b0}}, cin};

        case (op_alu)
            4'b0000: alu_data = x;
            4'b0001: alu_data = ~x;
            4'b0010: alu_data = x & y;
            4'b0011: alu_data = ~(x & y);
            4'b0110: alu_data = x | y;
            4'b0111: alu_data = ~(x | y);
            4'b1010: alu_data = x ^ y;
            4'b1011: alu_data = ~(x ^ y);
            4'b1110: alu_data = y;
            4'b1111: alu_data = ~y;
            default: alu_data = sum[WIDTH-1:0];
        endcase
        is_add    = (op_alu[3] | op_alu[2]) & ~op_alu[1];
        alu_carry = is_add ? sum[WIDTH] : cf_eff;
`ifdef ALU_OVF_EN
        alu_vf = is_add && (xa[WIDTH-1] == ya[WIDTH-1]) && (sum[WIDTH-1] != xa[WIDTH-1]);
`endif

        // shift step operates on the registered {carry, data}
        d = result[WIDTH-1:0];
        c = result[WIDTH];
        case (mode)
            3'b001:  shf_next = {d, 1'b0};
            3'b010:  shf_next = {d, c};
            3'b011:  shf_next = {d[0], 1'b0, d[WIDTH-1:1]};
            3'b100:  shf_next = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            3'b101:  shf_next = {d[0], c, d[WIDTH-1:1]};
            3'b110:  shf_next = {d, d[WIDTH-1]};
            3'b111:  shf_next = {d[0], d[0], d[WIDTH-1:1]};
            default: shf_next = result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            mode      <= 3'b000;
            cnt       <= '0;
`ifdef ALU_OVF_EN
            vf        <= 1'b0;
            vf_pend   <= 1'b0;
`endif
        end else begin
            if (cf_wr)
                cf <= cf_wdata;
            else if (drain)
                cf <= result[WIDTH];
            if (drain) begin
                zf <= (result[WIDTH-1:0] == '0);
`ifdef ALU_OVF_EN
                vf <= vf_pend;
`endif
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        result <= {alu_carry, alu_data};
                        mode   <= op_shf;
                        cnt    <= shamt;
`ifdef ALU_OVF_EN
                        vf_pend <= do_shift ? 1'b0 : alu_vf;
`endif
                        if (do_shift) begin
                            state     <= S_SHIFT;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end
                    end else if (drain) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    result <= shf_next;
                    cnt    <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16, SHAMT_W=4): hand-computed vectors, handshakes, reset abort.
module tb_alu_seq;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op_alu;
    logic [2:0]  op_shf;
    logic [3:0]  shamt;
    logic [15:0] x, y;
    logic [16:0] result;
    logic        cf, zf, cf_wr, cf_wdata;
`ifdef ALU_OVF_EN
    logic        vf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_alu(op_alu), .op_shf(op_shf), .shamt(shamt), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cf(cf), .zf(zf), .cf_wr(cf_wr), .cf_wdata(cf_wdata)
`ifdef ALU_OVF_EN
        , .vf(vf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // offer one op (consumer not ready), measure accept->out_valid latency and check result
    task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] shf,
                          input logic [3:0] sh, input logic [15:0] xv, input logic [15:0] yv,
                          input int exp_lat, input logic [16:0] exp_res);
        int lat;
        chk({tag, "_rdy"}, in_ready, 1);
        op_alu = op; op_shf = shf; shamt = sh; x = xv; y = yv;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
    endtask

    task automatic drain_chk(input string tag, input logic exp_cf, input logic exp_zf);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_cf"}, cf, exp_cf);
        chk({tag, "_zf"}, zf, exp_zf);
    endtask

    initial begin
        int seen;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cf_wr = 1'b0; cf_wdata = 1'b0;
        op_alu = '0; op_shf = '0; shamt = '0; x = '0; y = '0;

        // 1: mid-cycle async reset
        @(posedge clk); #2 rst = 1'b1; #4 rst = 1'b0;
        chk("rst_ov", out_valid, 0);
        chk("rst_cf", cf, 0);
        chk("rst_zf", zf, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_res", result, 0);
        step();

        // 2: add with carry out, held pending
        run_op("add", 4'b1000, 3'b000, 4'd0, 16'hFFFF, 16'h0001, 1, 17'h10000);

        // 3: back-to-back accept in the drain cycle; ADC uses bypassed carry 1
        op_alu = 4'b1001; op_shf = 3'b000; shamt = 4'd0; x = 16'h0001; y = 16'h0001;
        in_valid = 1'b1; out_ready = 1'b1;
        #0 chk("b2b_rdy", in_ready, 1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_cf", cf, 1);
        chk("b2b_zf", zf, 1);
        chk("b2b_ov", out_valid, 1);
        chk("b2b_res", result, 17'h00003);
        drain_chk("b2b_drn", 0, 0);

        // 4: ASR by 3
        run_op("asr", 4'b0000, 3'b100, 4'd3, 16'h8001, 16'h0000, 4, 17'h0F000);
        drain_chk("asr_drn", 0, 0);

        // 5: stall 5 cycles, then drain with a simultaneous cf write of 0
        run_op("stall", 4'b1000, 3'b000, 4'd0, 16'hFFFF, 16'h0001, 1, 17'h10000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_res", result, 17'h10000);
            chk("stall_rdy", in_ready, 0);
            chk("stall_ov", out_valid, 1);
        end
        out_ready = 1'b1; cf_wr = 1'b1; cf_wdata = 1'b0;
        step();
        out_ready = 1'b0; cf_wr = 1'b0;
        chk("cfwr_cf", cf, 0);
        chk("cfwr_zf", zf, 1);
        chk("cfwr_ov", out_valid, 0);

        // 6: ROR by 5 aborted by reset two cycles into the shift
        op_alu = 4'b0000; op_shf = 3'b111; shamt = 4'd5; x = 16'h1234; y = 16'h0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1; #2 rst = 1'b0;
        chk("abort_ov", out_valid, 0);
        chk("abort_res", result, 0);
        chk("abort_rdy", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("abort_silent", seen, 0);
        run_op("sub", 4'b0100, 3'b000, 4'd0, 16'h0005, 16'h0003, 1, 17'h10002);
        drain_chk("sub_drn", 1, 0);

        // logic op passes cf through; shift mode with shamt=0 completes without shifting
        run_op("xor", 4'b1010, 3'b011, 4'd0, 16'hF0F0, 16'hFF00, 1, 17'h10FF0);
        drain_chk("xor_drn", 1, 0);
        run_op("ror1", 4'b0000, 3'b111, 4'd1, 16'h0001, 16'h0000, 2, 17'h18000);
        drain_chk("ror1_drn", 1, 0);
        run_op("shl15", 4'b0000, 3'b001, 4'd15, 16'h0003, 16'h0000, 16, 17'h18000);
        drain_chk("shl15_drn", 1, 0);
        run_op("rcr2", 4'b0000, 3'b101, 4'd2, 16'h0002, 16'h0000, 3, 17'h14000);
        drain_chk("rcr2_drn", 1, 0);
        run_op("borrow", 4'b0100, 3'b000, 4'd0, 16'h0003, 16'h0005, 1, 17'h0FFFE);
        drain_chk("borrow_drn", 0, 0);
        run_op("nor", 4'b0111, 3'b000, 4'd0, 16'h0000, 16'h0000, 1, 17'h0FFFF);
        drain_chk("nor_drn", 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
